// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide memory port between fetch (IF) and load/store (LSB), serialising 1/2/4-byte accesses
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter bit IO_STALL_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  state_t state;
  logic [2:0] cnt, len;
  logic [31:0] wdata, rdata, rdata_nxt;
  logic [7:0] wbyte_nxt;
  logic [ADDR_W-1:0] a_inc;
  logic accept, stall_new, stall_inc, stall_cur;
  always_comb begin
    a_inc = mem_a + ADDR_W'(1);
    rdata_nxt = rdata | ({24'b0, mem_din} << {cnt - 3'd1, 3'b0});
    wbyte_nxt = 8'(wdata >> {cnt + 3'd1, 3'b0});
    accept = !clr_in && !if_done && !ls_done && (if_req || ls_req);
    stall_new = IO_STALL_EN && io_buffer_full && (ls_addr[17:16] == 2'b11);
    stall_inc = IO_STALL_EN && io_buffer_full && (a_inc[17:16] == 2'b11);
    stall_cur = IO_STALL_EN && io_buffer_full && (mem_a[17:16] == 2'b11);
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= 3'd0;
      len <= 3'd0;
      wdata <= 32'd0;
      rdata <= 32'd0;
      mem_a <= '0;
      mem_dout <= 8'd0;
      mem_wr <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if_data <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= ls_req ? (ls_wr ? LS_WR : LS_RD) : IF_RD;
          cnt <= 3'd0;
          rdata <= 32'd0;
          len <= !ls_req ? 3'd4 : ls_len == 2'd0 ? 3'd1 : ls_len == 2'd1 ? 3'd2 : 3'd4;
          mem_a <= ls_req ? ls_addr : if_addr;
          wdata <= ls_wdata;
          mem_dout <= ls_wdata[7:0];
          mem_wr <= ls_req && ls_wr && !stall_new;
        end
        IF_RD, LS_RD: if (clr_in) begin
          state <= IDLE;
          cnt <= 3'd0;
        end else begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rdata <= rdata_nxt;
          if (cnt + 3'd1 < len) mem_a <= a_inc;
          if (cnt == len) begin
            state <= IDLE;
            cnt <= 3'd0;
            if_done <= state == IF_RD;
            ls_done <= state == LS_RD;
            if (state == IF_RD) if_data <= rdata_nxt;
            else ls_rdata <= rdata_nxt;
          end
        end
        LS_WR: if (!mem_wr) mem_wr <= !stall_cur;
        else if (cnt + 3'd1 == len) begin
          state <= IDLE;
          cnt <= 3'd0;
          mem_wr <= 1'b0;
          ls_done <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
          mem_a <= a_inc;
          mem_dout <= wbyte_nxt;
          mem_wr <= !stall_inc;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with byte RAM model, directed timing scenarios and randomised traffic
module tb_mem_port_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr_in, io_buffer_full;
  logic [7:0] mem_din = 8'h00;
  logic [7:0] mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic ls_req, ls_wr, ls_done;
  logic [1:0] ls_len;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  typedef struct packed {logic wr; logic [31:0] data;} ls_t;
  logic [31:0] if_exp[$];
  ls_t ls_exp[$];
  logic [31:0] if_e;
  ls_t ls_e;
  logic [7:0] ram [0:262143];
  logic [7:0] ref_mem [0:262143];
  logic rdy_s = 1'b0, io_s = 1'b0;
  bit stop = 1'b0;
  int checks = 0, errors = 0;
  mem_port_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data), .ls_req(ls_req), .ls_wr(ls_wr),
    .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .ls_rdata(ls_rdata)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [7:0] init_byte(input int i);
    return i == 'h100 ? 8'h13 : i == 'h101 ? 8'h05 : (i == 'h102 || i == 'h103) ? 8'h00 :
           i == 'h10 ? 8'hFF : 8'(i * 37 + (i / 256) * 11 + 5);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a, input int n);
    logic [31:0] d = 32'd0;
    for (int i = 0; i < n; i++) d[8*i+:8] = ref_mem[18'(a + 32'(i))];
    return d;
  endfunction
  initial begin
    for (int i = 0; i < 262144; i++) ram[i] <= init_byte(i);
    forever begin
      @(posedge clk_in);
      rdy_s <= rdy_in;
      io_s <= io_buffer_full;
      if (rdy_in) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      end
    end
  end
  always @(negedge clk_in) begin
    if (rst_in && rdy_s) begin
      if (if_done) begin
        checks++;
        if (if_exp.size() == 0) begin
          errors++;
          $display("FAIL if_unexpected: if_done with if_data=%h, no fetch outstanding", if_data);
        end else begin
          if_e = if_exp.pop_front();
          if (if_data !== if_e) begin
            errors++;
            $display("FAIL if_data: got %h expected %h", if_data, if_e);
          end
        end
      end
      if (ls_done) begin
        if (ls_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ls_unexpected: ls_done with ls_rdata=%h, no access outstanding", ls_rdata);
        end else begin
          ls_e = ls_exp.pop_front();
          if (!ls_e.wr) begin
            checks++;
            if (ls_rdata !== ls_e.data) begin
              errors++;
              $display("FAIL ls_rdata: got %h expected %h", ls_rdata, ls_e.data);
            end
          end
        end
      end
      if (mem_wr && mem_a[17:16] == 2'b11) begin
        checks++;
        if (io_s) begin
          errors++;
          $display("FAIL io_stall: mem_wr=1 at %h got io_buffer_full=1 expected 0", mem_a);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic if_issue(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    if_exp.push_back(ref_rd(a, 4));
  endtask
  task automatic ls_issue(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    int n = len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
    ls_t e;
    ls_req = 1'b1;
    ls_wr = wr;
    ls_len = len;
    ls_addr = a;
    ls_wdata = wd;
    e.wr = wr;
    e.data = wr ? 32'd0 : ref_rd(a, n);
    if (wr) for (int i = 0; i < n; i++) ref_mem[18'(a + 32'(i))] = wd[8*i+:8];
    ls_exp.push_back(e);
  endtask
  task automatic wait_done(input bit is_if);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_in);
      if (rdy_s && (is_if ? if_done : ls_done)) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no done pulse expected one within 3000 cycles", is_if ? "if" : "ls");
  endtask
  task automatic if_agent(input int n);
    for (int i = 0; i < n; i++) begin
      if_issue(32'($urandom_range(0, 'hFF0)));
      wait_done(1'b1);
      if_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
  endtask
  task automatic ls_agent(input int n);
    for (int i = 0; i < n; i++) begin
      ls_issue(1'($urandom), 2'($urandom),
               ($urandom % 2) ? 32'h1000 + 32'($urandom_range(0, 60)) : 32'h30000 + 32'($urandom_range(0, 60)),
               $urandom);
      wait_done(1'b0);
      ls_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
  endtask
  initial begin
    logic [31:0] ea;
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    for (int i = 0; i < 262144; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(negedge clk_in);
    chk("reset_outputs", {mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata}, 128'd0);
    rst_in = 1'b1;
    @(negedge clk_in);
    if_issue(32'h100);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      chk("if_mem_a", mem_a, k <= 4 ? 32'h100 + 32'(k) - 32'd1 : 32'h103);
      chk("if_done_timing", if_done, k == 6);
    end
    chk("if_data_0x100", if_data, 32'h00000513);
    if_req = 1'b0;
    @(negedge clk_in);
    if_issue(32'h104);
    ls_issue(1'b0, 2'd2, 32'h200, 32'd0);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk_in);
      ea = k <= 4 ? 32'h200 + 32'(k) - 32'd1 : k <= 7 ? 32'h203 : k <= 11 ? 32'h104 + 32'(k) - 32'd8 : 32'h107;
      chk("arb_mem_a", mem_a, ea);
      chk("arb_ls_done", ls_done, k == 6);
      chk("arb_if_done", if_done, k == 13);
      if (k == 6) ls_req = 1'b0;
    end
    if_req = 1'b0;
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    ls_issue(1'b1, 2'd1, 32'h30000, 32'h4241);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      chk("io_mem_wr", mem_wr, k == 4 || k == 5);
      chk("io_mem_a", mem_a, k <= 4 ? 32'h30000 : 32'h30001);
      chk("io_mem_dout", mem_dout, k <= 4 ? 8'h41 : 8'h42);
      chk("io_ls_done", ls_done, k == 6);
      if (k == 3) io_buffer_full = 1'b0;
    end
    ls_issue(1'b0, 2'd1, 32'h30000, 32'd0);
    wait_done(1'b0);
    chk("io_readback", ls_rdata, 32'h4241);
    ls_req = 1'b0;
    @(negedge clk_in);
    if_req = 1'b1;
    if_addr = 32'h108;
    repeat (2) @(negedge clk_in);
    clr_in = 1'b1;
    if_req = 1'b0;
    ls_issue(1'b0, 2'd0, 32'h10, 32'd0);
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk_in);
      if (k == 3) clr_in = 1'b0;
      chk("flush_no_if_done", if_done, 1'b0);
      chk("flush_ls_done", ls_done, k == 6);
    end
    chk("flush_ls_rdata", ls_rdata, 32'h000000FF);
    ls_req = 1'b0;
    @(negedge clk_in);
    ls_issue(1'b0, 2'd2, 32'h204, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_in);
      ea = k == 1 ? 32'h204 : k <= 7 ? 32'h205 : k == 8 ? 32'h206 : 32'h207;
      chk("rdy_mem_a", mem_a, ea);
      chk("rdy_ls_done", ls_done, k == 11);
      if (k == 2) rdy_in = 1'b0;
      if (k == 7) rdy_in = 1'b1;
    end
    chk("rdy_ls_rdata", ls_rdata, ref_rd(32'h204, 4));
    ls_req = 1'b0;
    @(negedge clk_in);
    ls_issue(1'b0, 2'd2, 32'h208, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("reset_mid_outputs", {mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata}, 128'd0);
    ls_exp.delete();
    ls_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      chk("post_reset_quiet", {ls_done, mem_wr}, 2'b00);
    end
    fork
      begin
        fork
          if_agent(40);
          ls_agent(40);
        join
        stop = 1'b1;
      end
      while (!stop) begin
        @(negedge clk_in);
        clr_in = ($urandom % 20) == 0;
        rdy_in = ($urandom % 6) != 0;
        io_buffer_full = ($urandom % 3) == 0;
      end
    join
    clr_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("scoreboard_drain", if_exp.size() + ls_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM/IO port between instruction fetch (IF) and the load/store buffer (LSB).
- Arbitrates between the two requesters and serialises each 1/2/4-byte access into per-byte memory cycles.
- Assembles read bytes little-endian and returns a one-cycle done pulse to the owning requester.
- Sits between IF/LSB and the top-level mem_din/mem_dout/mem_a/mem_wr pins; honours the flush signal and UART back-pressure.

Parameters:
ADDR_W, 32, address width of requests and mem_a
IO_STALL_EN, 1, when 1, IO writes stall while io_buffer_full is high

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; low freezes all state and holds all outputs
clr_in  in  1  misprediction flush
io_buffer_full  in  1  UART tx buffer full
mem_din  in  8  read byte (valid the cycle after its address)
mem_dout  out  8  write byte
mem_a  out  ADDR_W  byte address
mem_wr  out  1  1 = write this cycle
if_req  in  1  IF fetch request (level, held until if_done)
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
ls_req  in  1  LSB request (level, held until ls_done)
ls_wr  in  1  1 = store
ls_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (3 is illegal, treated as 4 bytes)
ls_addr  in  ADDR_W  access address
ls_wdata  in  32  store data, low bytes first
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended

Behaviour:
- Reset (rst_in=0, async): state=IDLE, counter=0. All outputs are 0: mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata.
- Outputs are registered. When idle: mem_wr=0 and mem_a holds its last value.
- rdy_in=0: no register changes; request acceptance and memory sequencing are suspended.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- IDLE arbitration, evaluated each cycle with clr_in=0:
  - ls_req has priority and enters LS_WR if ls_wr=1, else LS_RD.
  - Otherwise if_req enters IF_RD.
  - On acceptance, latch the address, N (4 for IF; 1/2/4 per ls_len) and write data.
  - No new request is accepted in the cycle a done pulse is high.
- Read timing, N bytes, accepted at the edge ending cycle T:
  - mem_a = base+k in cycle T+1+k, for k = 0..N-1.
  - Byte k is sampled from mem_din in cycle T+2+k into bits [8k+7:8k]; unused upper bytes are 0.
  - done is high in cycle T+N+2 with the data valid; the next state is IDLE.
  - Total latency: N+2 cycles from acceptance to done.
- Write timing, N bytes:
  - In cycle T+1+k: mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr=1.
  - ls_done is high in cycle T+N+1; mem_wr=0 in that cycle.
- IO stall: for a write byte with address[17:16]==2'b11, IO_STALL_EN=1 and io_buffer_full=1:
  - hold mem_wr=0 and keep the counter;
  - present the byte in the first cycle io_buffer_full is low.
- Counter is 3 bits wide; address increments use full ADDR_W wraparound.
- Flush (clr_in=1):
  - IF_RD or LS_RD: abort to IDLE next cycle, mem_wr=0, no done pulse. Any byte still returning is ignored.
  - LS_WR: not aborted, because stores reaching memory are committed; it completes normally.
  - IDLE: no acceptance that cycle.
  - clr_in during a done cycle: the done pulse is still emitted. The requester discards it.
- Requester-side rules: a requester must keep req and its operands stable until its done pulse. If req drops before acceptance, nothing is issued.
- Simultaneous if_req and ls_req in IDLE: LSB wins. IF waits and is served on the next IDLE cycle with ls_req low.

Test Plan:
- Reset mid-LS_RD: assert rst_in=0 with the counter at 2 -> all outputs are 0 immediately. After release, state is IDLE and no ls_done pulse occurs.
- IF fetch at 0x100, RAM bytes 13 05 00 00 -> mem_a = 0x100..0x103 in cycles T+1..T+4; if_done pulses in T+6 with if_data=0x00000513.
- Concurrent requests: if_req and ls_req (4-byte load at 0x200) both asserted in the same cycle -> load is served first. IF acceptance comes after ls_done, and mem_a never interleaves the two.
- Store of 2 bytes at 0x30000, ls_wdata=0x4241, io_buffer_full held high 3 cycles -> mem_wr stays low 3 cycles. Then 0x41 and 0x42 are written on consecutive cycles; ls_done follows.
- clr_in pulse during IF_RD (after 2 bytes) -> no if_done, IDLE next cycle. A pending 1-byte ls_req at 0x10 (RAM 0xFF) then returns ls_rdata=0x000000FF.
- rdy_in low 5 cycles during LS_RD -> mem_a and counter frozen; after resume, data and latency are the same as an uninterrupted read plus 5 cycles.
